// File: rtl/bus_transaction_controller.sv
// Sequences one serial bus transaction for the granted master: decodes the slave ID,
// forwards mode/address/write data to the selected slave and returns read data.
module bus_transaction_controller #(
    parameter int NUM_SLAVES = 3,
    parameter int SLAVE_ID_W = 2,
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  grant_valid,
    input  logic                  m_tx,
    input  logic                  m_tx_valid,
    output logic                  m_rx,
    output logic                  m_rx_valid,
    output logic [NUM_SLAVES-1:0] slave_sel,
    output logic                  s_tx,
    output logic                  s_tx_valid,
    input  logic                  s_rx,
    input  logic                  s_rx_valid,
    input  logic                  s_ready,
    output logic                  busy,
    output logic                  txn_done,
    output logic                  txn_error
);

    localparam int CNT_MAX = ((ADDR_W + 1) > DATA_W) ? (ADDR_W + 1) : DATA_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDLE_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE,
        ID,
        HDR,
        WDATA,
        WAIT_ACK,
        RDATA,
        DONE,
        ERR,
        RELEASE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [IDLE_W-1:0]       idle_cnt_q, idle_cnt_d;
    logic [IDLE_W-1:0]       idle_inc;
    logic                    timed_out;
    logic [SLAVE_ID_W-1:0]   id_q, id_d;
    logic                    mode_q, mode_d;
    logic [NUM_SLAVES-1:0]   sel_q, sel_d;
    logic                    s_tx_q, s_tx_d;
    logic                    s_tx_valid_q, s_tx_valid_d;
    logic                    m_rx_q, m_rx_d;
    logic                    m_rx_valid_q, m_rx_valid_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            idle_cnt_q   <= '0;
            id_q         <= '0;
            mode_q       <= 1'b0;
            sel_q        <= '0;
            s_tx_q       <= 1'b0;
            s_tx_valid_q <= 1'b0;
            m_rx_q       <= 1'b0;
            m_rx_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            id_q         <= id_d;
            mode_q       <= mode_d;
            sel_q        <= sel_d;
            s_tx_q       <= s_tx_d;
            s_tx_valid_q <= s_tx_valid_d;
            m_rx_q       <= m_rx_d;
            m_rx_valid_q <= m_rx_valid_d;
        end
    end

    assign idle_inc  = idle_cnt_q + 1'b1;
    assign timed_out = (idle_inc == IDLE_W'(TIMEOUT));

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        id_d         = id_q;
        mode_d       = mode_q;
        sel_d        = sel_q;
        s_tx_d       = 1'b0;
        s_tx_valid_d = 1'b0;
        m_rx_d       = 1'b0;
        m_rx_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_valid && m_tx_valid) begin
                    id_d      = {m_tx, id_q[SLAVE_ID_W-1:1]};
                    bit_cnt_d = CNT_W'(1);
                    state_d   = ID;
                end
            end
            ID: begin
                if (!grant_valid) begin
                    state_d = ERR;
                end else if (m_tx_valid) begin
                    // ID shifts in LSB first; after the last bit id_d holds the full field.
                    id_d       = {m_tx, id_q[SLAVE_ID_W-1:1]};
                    idle_cnt_d = '0;
                    if (bit_cnt_q == CNT_W'(SLAVE_ID_W - 1)) begin
                        if (32'(id_d) >= NUM_SLAVES) begin
                            state_d = ERR;
                        end else begin
                            sel_d   = NUM_SLAVES'(1) << id_d;
                            state_d = HDR;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (timed_out) begin
                    state_d = ERR;
                end else begin
                    idle_cnt_d = idle_inc;
                end
            end
            HDR: begin
                if (!grant_valid) begin
                    state_d = ERR;
                end else if (m_tx_valid) begin
                    s_tx_d       = m_tx;
                    s_tx_valid_d = 1'b1;
                    idle_cnt_d   = '0;
                    if (bit_cnt_q == '0) begin
                        mode_d = m_tx;
                    end
                    if (bit_cnt_q == CNT_W'(ADDR_W)) begin
                        state_d = mode_q ? WDATA : RDATA;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (timed_out) begin
                    state_d = ERR;
                end else begin
                    idle_cnt_d = idle_inc;
                end
            end
            WDATA: begin
                if (!grant_valid) begin
                    state_d = ERR;
                end else if (m_tx_valid) begin
                    s_tx_d       = m_tx;
                    s_tx_valid_d = 1'b1;
                    idle_cnt_d   = '0;
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = WAIT_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (timed_out) begin
                    state_d = ERR;
                end else begin
                    idle_cnt_d = idle_inc;
                end
            end
            WAIT_ACK: begin
                if (!grant_valid) begin
                    state_d = ERR;
                end else if (s_ready) begin
                    state_d = DONE;
                end else if (timed_out) begin
                    state_d = ERR;
                end else begin
                    idle_cnt_d = idle_inc;
                end
            end
            RDATA: begin
                if (!grant_valid) begin
                    state_d = ERR;
                end else if (s_rx_valid) begin
                    m_rx_d       = s_rx;
                    m_rx_valid_d = 1'b1;
                    idle_cnt_d   = '0;
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (timed_out) begin
                    state_d = ERR;
                end else begin
                    idle_cnt_d = idle_inc;
                end
            end
            DONE:    state_d = RELEASE;
            ERR:     state_d = RELEASE;
            RELEASE: begin
                if (!grant_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Slave select drops as the pulse state is entered; counters restart per state.
        if (state_d == DONE || state_d == ERR) begin
            sel_d = '0;
        end
        if (state_d != state_q) begin
            idle_cnt_d = '0;
            if (state_d != ID) begin
                bit_cnt_d = '0;
            end
        end
    end

    assign busy       = (state_q != IDLE);
    assign txn_done   = (state_q == DONE);
    assign txn_error  = (state_q == ERR);
    assign slave_sel  = sel_q;
    assign s_tx       = s_tx_q;
    assign s_tx_valid = s_tx_valid_q;
    assign m_rx       = m_rx_q;
    assign m_rx_valid = m_rx_valid_q;

endmodule
